adder_subtractor: RTL and testbench

ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

---
 rtl/adder_subtractor.sv | 45 ++++
 tb/tb_adder_subtractor.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/adder_subtractor.sv
// rtl/adder_subtractor.sv - registered signed ripple-carry adder/subtractor with overflow flag
module adder_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op
);

    logic [WIDTH-1:0] s_d, s_q;
    logic             overflow_d, overflow_q;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   carry;

    // Subtract reuses the adder: invert b and inject op as carry-in.
    always_comb begin
        b_x      = b ^ {WIDTH{op}};
        carry    = '0;
        carry[0] = op;
        s_d      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s_d[i]       = a[i] ^ b_x[i] ^ carry[i];
            carry[i + 1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
        end
        overflow_d = carry[WIDTH] ^ carry[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            overflow_q <= overflow_d;
        end
    end

    assign s        = s_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// tb/tb_adder_subtractor.sv - self-checking bench for adder_subtractor
module tb_adder_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] s;
    logic             overflow;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;

    int n_cmp;
    int n_bad;

    adder_subtractor #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (s),
        .overflow (overflow),
        .a        (a),
        .b        (b),
        .op       (op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        bit op;
        int es;
        bit eo;
    } vec_t;

    vec_t vecs[22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int va, input int vb, input bit vop);
        a  = WIDTH'(va);
        b  = WIDTH'(vb);
        op = vop;
    endtask

    task automatic check(input string name, input int es, input bit eo);
        logic [WIDTH-1:0] exp_s;
        exp_s = WIDTH'(es);
        n_cmp++;
        if (s !== exp_s || overflow !== eo) begin
            n_bad++;
            $display("FAIL %s: got s=%0d ov=%0b, expected s=%0d ov=%0b",
                     name, $signed(s), overflow, $signed(exp_s), eo);
        end
    endtask

    // Reference: exact integer arithmetic, overflow when outside the signed range.
    task automatic model(input int va, input int vb, input bit vop, output int es, output bit eo);
        int res;
        res = vop ? (va - vb) : (va + vb);
        eo  = (res > 127) || (res < -128);
        es  = res;
    endtask

    initial begin
        int es;
        bit eo;
        int ra, rb;
        bit rop;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{1, 1, 1'b0, 2, 1'b0};
        vecs[1]  = '{1, 1, 1'b1, 0, 1'b0};
        vecs[2]  = '{1, -1, 1'b0, 0, 1'b0};
        vecs[3]  = '{1, -1, 1'b1, 2, 1'b0};
        vecs[4]  = '{-1, 1, 1'b0, 0, 1'b0};
        vecs[5]  = '{-1, 1, 1'b1, -2, 1'b0};
        vecs[6]  = '{-1, -1, 1'b0, -2, 1'b0};
        vecs[7]  = '{-1, -1, 1'b1, 0, 1'b0};
        vecs[8]  = '{127, 1, 1'b0, -128, 1'b1};
        vecs[9]  = '{127, 1, 1'b1, 126, 1'b0};
        vecs[10] = '{127, -1, 1'b0, 126, 1'b0};
        vecs[11] = '{127, -1, 1'b1, -128, 1'b1};
        vecs[12] = '{-127, 1, 1'b0, -126, 1'b0};
        vecs[13] = '{-127, 1, 1'b1, -128, 1'b0};
        vecs[14] = '{-127, -1, 1'b0, -128, 1'b0};
        vecs[15] = '{-127, -1, 1'b1, -126, 1'b0};
        vecs[16] = '{-128, -1, 1'b0, 127, 1'b1};
        vecs[17] = '{0, -128, 1'b1, -128, 1'b1};
        vecs[18] = '{-1, -128, 1'b1, 127, 1'b0};
        vecs[19] = '{-128, -128, 1'b0, 0, 1'b1};
        vecs[20] = '{-128, 1, 1'b1, 127, 1'b1};
        vecs[21] = '{0, 0, 1'b1, 0, 1'b0};

        // Reset with inputs that would otherwise overflow.
        rst = 1'b1;
        apply(127, 1, 1'b0);
        step();
        step();
        check("reset_state", 0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].op);
            step();
            check($sformatf("table_%0d", i), vecs[i].es, vecs[i].eo);
        end

        // Latency and hold between edges.
        apply(127, 1, 1'b0);
        step();
        check("lat_edge_n", -128, 1'b1);
        apply(1, 1, 1'b0);
        #2;
        apply(5, 7, 1'b1);
        #2;
        check("lat_hold_toggle", -128, 1'b1);
        apply(1, 1, 1'b0);
        step();
        check("lat_edge_n1", 2, 1'b0);

        // Reset mid-stream discards the sampled operation.
        apply(127, -1, 1'b1);
        rst = 1'b1;
        step();
        check("rst_mid", 0, 1'b0);
        rst = 1'b0;
        apply(5, 3, 1'b1);
        step();
        check("rst_release", 2, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            ra  = $signed(8'($urandom));
            rb  = $signed(8'($urandom));
            rop = 1'($urandom);
            apply(ra, rb, rop);
            model(ra, rb, rop, es, eo);
            step();
            check("random", es, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
